// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS issue controller.
//   - ILLEGAL_MASK : opcode bits that must be 0 for a legal instruction
//   - WREG_*       : the six register addresses the datapath actually writes
//   - is_legal / dest_of / writes_reg / reads_rt : instruction decode helpers
//   - req_id_t     : requester index wide enough for the largest requester count
package mips_pkg;

    localparam int MAX_REQ = 4;

    // Bits 31, 30, 28, 27 and 26 must all be clear.
    localparam logic [31:0] ILLEGAL_MASK = 32'hDC00_0000;

    localparam logic [4:0] WREG_A = 5'b10001;
    localparam logic [4:0] WREG_B = 5'b10010;
    localparam logic [4:0] WREG_C = 5'b01000;
    localparam logic [4:0] WREG_D = 5'b10111;
    localparam logic [4:0] WREG_E = 5'b11111;
    localparam logic [4:0] WREG_F = 5'b10000;

    typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

    function automatic logic is_legal(input logic [31:0] instr);
        return (instr & ILLEGAL_MASK) == 32'h0;
    endfunction

    // I-type (bit 29 set) writes rt, otherwise rd.
    function automatic logic [4:0] dest_of(input logic [31:0] instr);
        return instr[29] ? instr[20:16] : instr[15:11];
    endfunction

    function automatic logic writes_reg(input logic [31:0] instr);
        logic hit;
        case (dest_of(instr))
            WREG_A, WREG_B, WREG_C, WREG_D, WREG_E, WREG_F: hit = 1'b1;
            default:                                        hit = 1'b0;
        endcase
        return hit && is_legal(instr);
    endfunction

    // rt is an operand only for register-register (non I-type) forms.
    function automatic logic reads_rt(input logic [31:0] instr);
        return !instr[29];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with an internal rotating pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector
//   advance    : move the pointer to grant_id+1 (mod N) at the next edge
//   grant      : one-hot grant (all zero when nothing requests)
//   grant_id   : index of the granted requester
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           req,
    input  logic                   advance,
    output logic [N-1:0]           grant,
    output logic [$clog2(N)-1:0]   grant_id
);

    localparam int ID_W = $clog2(N);

    logic [ID_W-1:0] ptr_reg;
    logic            found;
    int              idx;

    // Scan requesters starting at the pointer, first hit wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_reg) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (advance) begin
            ptr_reg <= (int'(grant_id) == N - 1) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/mips_issue_arbiter.sv
// mips_issue_arbiter: shares the 2-stage MIPS datapath among NUM_REQ requesters.
// Round-robin issue, optional one-cycle bubble on a read-after-write hazard,
// and per-instruction tags so each completion is routed back to its owner.
//   Build option: define MIPS_HAZARD_STALL_EN to enable hazard stalls; without
//   it the winner is always accepted.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_valid/instr/ready  : per-requester instruction handshake
//   mips_in_valid          : registered issue strobe to the datapath
//   mips_instruction       : registered issued instruction
//   mips_out_valid         : datapath completion
//   mips_instruction_fail  : datapath fail flag (qualified by mips_out_valid)
//   resp_valid/id/fail     : registered completion routed to the owner
//   busy                   : issue register or any tag valid
//   proto_err              : sticky, completion arrived with no tag
module mips_issue_arbiter
    import mips_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int MIPS_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0][31:0]   req_instr,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       mips_in_valid,
    output logic [31:0]                mips_instruction,
    input  logic                       mips_out_valid,
    input  logic                       mips_instruction_fail,
    output logic                       resp_valid,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic                       resp_fail,
    output logic                       busy,
    output logic                       proto_err
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic [31:0]        win_instr;
    logic               hazard;
    logic               accept;

    logic               issue_valid_reg;
    logic [31:0]        issue_instr_reg;
    logic [ID_W-1:0]    issue_id_reg;

    logic [MIPS_LAT-1:0] tag_valid_reg;
    logic [MIPS_LAT-1:0] tag_valid_next;
    logic [ID_W-1:0]     tag_id_reg  [MIPS_LAT];
    logic [ID_W-1:0]     tag_id_next [MIPS_LAT];
    logic                head_valid;
    logic [ID_W-1:0]     head_id;

    logic               resp_valid_reg;
    logic [ID_W-1:0]    resp_id_reg;
    logic               resp_fail_reg;
    logic               proto_err_reg;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_valid),
        .advance  (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_comb begin
        win_instr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_instr = req_instr[i];
            end
        end
    end

`ifdef MIPS_HAZARD_STALL_EN
    // Only the instruction issued last cycle can still be unwritten; anything
    // older has already been written back by the datapath.
    logic [4:0] wr_dest;
    assign wr_dest = dest_of(issue_instr_reg);
    assign hazard  = issue_valid_reg && writes_reg(issue_instr_reg) && (|grant) &&
                     ((win_instr[25:21] == wr_dest) ||
                      (reads_rt(win_instr) && (win_instr[20:16] == wr_dest)));
`else
    assign hazard = 1'b0;
`endif

    assign accept    = (|grant) && !hazard;
    assign req_ready = hazard ? '0 : grant;

    // Issue register: a stall leaves mips_in_valid low, forming the bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid_reg <= 1'b0;
            issue_instr_reg <= '0;
            issue_id_reg    <= '0;
        end else begin
            issue_valid_reg <= accept;
            if (accept) begin
                issue_instr_reg <= win_instr;
                issue_id_reg    <= grant_id;
            end
        end
    end

    // Tag shift register; stage MIPS_LAT-1 lines up with mips_out_valid.
    for (genvar gi = 0; gi < MIPS_LAT; gi++) begin : g_tag
        if (gi == 0) begin : g_load
            assign tag_valid_next[gi] = issue_valid_reg;
            assign tag_id_next[gi]    = issue_id_reg;
        end else begin : g_shift
            assign tag_valid_next[gi] = tag_valid_reg[gi-1];
            assign tag_id_next[gi]    = tag_id_reg[gi-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_reg <= '0;
            for (int i = 0; i < MIPS_LAT; i++) begin
                tag_id_reg[i] <= '0;
            end
        end else begin
            tag_valid_reg <= tag_valid_next;
            for (int i = 0; i < MIPS_LAT; i++) begin
                tag_id_reg[i] <= tag_id_next[i];
            end
        end
    end

    assign head_valid = tag_valid_reg[MIPS_LAT-1];
    assign head_id    = tag_id_reg[MIPS_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_reg <= 1'b0;
            resp_id_reg    <= '0;
            resp_fail_reg  <= 1'b0;
            proto_err_reg  <= 1'b0;
        end else begin
            resp_valid_reg <= mips_out_valid && head_valid;
            if (mips_out_valid && head_valid) begin
                resp_id_reg   <= head_id;
                resp_fail_reg <= mips_instruction_fail;
            end
            if (mips_out_valid && !head_valid) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

    assign mips_in_valid    = issue_valid_reg;
    assign mips_instruction = issue_instr_reg;
    assign resp_valid       = resp_valid_reg;
    assign resp_id          = resp_id_reg;
    assign resp_fail        = resp_fail_reg;
    assign proto_err        = proto_err_reg;
    assign busy             = issue_valid_reg || (|tag_valid_reg);

endmodule

// File: tb/tb_mips_issue_arbiter.sv
// Scoreboard bench for mips_issue_arbiter. A stimulus process feeds per-requester
// instruction queues and a reference model predicts readies, issue order and
// responses; a monitor process pops expectations whenever the DUT shows
// mips_in_valid or resp_valid. The bench also plays the datapath, answering
// each issue MIPS_LAT cycles later with fail = !legal.
module tb_mips_issue_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int MIPS_LAT = 2;
    localparam int ID_W     = $clog2(NUM_REQ);
    localparam int MAXC     = 4096;
`ifdef MIPS_HAZARD_STALL_EN
    localparam bit HAZ_EN = 1'b1;
`else
    localparam bit HAZ_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ-1:0][31:0] req_instr = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     mips_in_valid;
    logic [31:0]              mips_instruction;
    logic                     mips_out_valid = 1'b0;
    logic                     mips_instruction_fail = 1'b0;
    logic                     resp_valid;
    logic [ID_W-1:0]          resp_id;
    logic                     resp_fail;
    logic                     busy;
    logic                     proto_err;

    mips_issue_arbiter #(.NUM_REQ(NUM_REQ), .MIPS_LAT(MIPS_LAT)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .req_valid             (req_valid),
        .req_instr             (req_instr),
        .req_ready             (req_ready),
        .mips_in_valid         (mips_in_valid),
        .mips_instruction      (mips_instruction),
        .mips_out_valid        (mips_out_valid),
        .mips_instruction_fail (mips_instruction_fail),
        .resp_valid            (resp_valid),
        .resp_id               (resp_id),
        .resp_fail             (resp_fail),
        .busy                  (busy),
        .proto_err             (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [31:0] instr; } iss_t;
    typedef struct { int cyc; int id; bit fail; logic [31:0] instr; } rsp_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          pending_pop = -1;
    logic [31:0] rq [NUM_REQ][$];
    iss_t        iss_q[$];
    rsp_t        rsp_q[$];
    bit          sched_valid [MAXC];
    bit          sched_fail  [MAXC];
    bit          busy_mark   [MAXC];
    int          m_ptr = 0;
    bit          m_last_valid = 1'b0;
    logic [31:0] m_last_instr = '0;
    bit          exp_proto = 1'b0;
    bit          spur_req = 1'b0;
    bit          spur_armed = 1'b0;
    int          wset [6] = '{17, 18, 8, 23, 31, 16};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit f_legal(input logic [31:0] x);
        return !(x[31] || x[30] || x[28] || x[27] || x[26]);
    endfunction

    // Does 'younger' read a register 'older' writes?
    function automatic bit model_hazard(input logic [31:0] older, input logic [31:0] younger);
        logic [4:0] d;
        bit         w;
        if (!f_legal(older)) return 1'b0;
        d = older[29] ? older[20:16] : older[15:11];
        w = 1'b0;
        foreach (wset[k]) if (int'(d) == wset[k]) w = 1'b1;
        if (!w) return 1'b0;
        if (younger[25:21] == d) return 1'b1;
        if (!younger[29] && younger[20:16] == d) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [5:0] ops  [5] = '{6'b001000, 6'b000000, 6'b000000, 6'b111111, 6'b001100};
        logic [4:0] regs [8] = '{5'd17, 5'd18, 5'd8, 5'd23, 5'd31, 5'd16, 5'd1, 5'd2};
        return {ops[$urandom_range(0, 4)], regs[$urandom_range(0, 7)],
                regs[$urandom_range(0, 7)], regs[$urandom_range(0, 7)], 11'h0};
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = (rq[i].size() > 0);
            req_instr[i] = (rq[i].size() > 0) ? rq[i][0] : 32'h0;
        end
    endtask

    // Reference arbitration for the current cycle (inputs already stable).
    task automatic model_eval();
        int                 win;
        bit                 haz;
        logic [NUM_REQ-1:0] exp_ready;
        logic [31:0]        ins;
        win = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NUM_REQ;
            if (win < 0 && rq[idx].size() > 0) win = idx;
        end
        haz = 1'b0;
        ins = '0;
        if (win >= 0) begin
            ins = rq[win][0];
            haz = HAZ_EN && m_last_valid && model_hazard(m_last_instr, ins);
        end
        exp_ready = '0;
        if (win >= 0 && !haz) exp_ready[win] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        if (win >= 0 && !haz) begin
            pending_pop = win;
            m_ptr = (win + 1) % NUM_REQ;
            iss_q.push_back('{cyc + 1, ins});
            rsp_q.push_back('{cyc + MIPS_LAT + 2, win, !f_legal(ins), ins});
            for (int c = cyc + 1; c <= cyc + 1 + MIPS_LAT; c++) busy_mark[c] = 1'b1;
            m_last_valid = 1'b1;
            m_last_instr = ins;
        end else begin
            m_last_valid = 1'b0;
        end
    endtask

    task automatic step(input bit rand_en);
        logic [31:0] tmp;
        @(posedge clk);
        #1;
        if (pending_pop >= 0) begin
            tmp = rq[pending_pop].pop_front();
            pending_pop = -1;
        end
        cyc++;
        if (spur_armed) begin
            exp_proto  = 1'b1;
            spur_armed = 1'b0;
        end
        if (rand_en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 99) < 45 && rq[i].size() < 3) rq[i].push_back(gen_instr());
            end
        end
        drive();
        mips_out_valid        = sched_valid[cyc] | spur_req;
        mips_instruction_fail = sched_fail[cyc];
        if (spur_req) begin
            spur_armed = 1'b1;
            spur_req   = 1'b0;
        end
        @(negedge clk);
        model_eval();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  64'(req_ready), 64'h0);
        check({tag, "_inv"},    64'(mips_in_valid), 64'h0);
        check({tag, "_instr"},  64'(mips_instruction), 64'h0);
        check({tag, "_rvalid"}, 64'(resp_valid), 64'h0);
        check({tag, "_rid"},    64'(resp_id), 64'h0);
        check({tag, "_rfail"},  64'(resp_fail), 64'h0);
        check({tag, "_busy"},   64'(busy), 64'h0);
        check({tag, "_perr"},   64'(proto_err), 64'h0);
    endtask

    task automatic do_reset();
        logic [31:0] tmp;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        if (pending_pop >= 0) begin
            tmp = rq[pending_pop].pop_front();
            pending_pop = -1;
        end
        cyc++;
        for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
        iss_q.delete();
        rsp_q.delete();
        for (int c = cyc; c < MAXC; c++) begin
            sched_valid[c] = 1'b0;
            busy_mark[c]   = 1'b0;
        end
        m_ptr = 0;
        m_last_valid = 1'b0;
        exp_proto = 1'b0;
        drive();
        mips_out_valid = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        cyc++;
        @(negedge clk);
        check_all_zero("midrst2");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        drive();
        @(negedge clk);
        model_eval();
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard.
    initial begin
        iss_t e;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("busy", 64'(busy), 64'(busy_mark[cyc]));
                check("proto_err", 64'(proto_err), 64'(exp_proto));
                if (mips_in_valid) begin
                    sched_valid[cyc + MIPS_LAT] = 1'b1;
                    sched_fail[cyc + MIPS_LAT]  = !f_legal(mips_instruction);
                    if (iss_q.size() == 0) begin
                        check("unexpected_issue", 64'(mips_in_valid), 64'h0);
                    end else begin
                        e = iss_q.pop_front();
                        check("issue_cycle", 64'(cyc), 64'(e.cyc));
                        check("issue_instr", 64'(mips_instruction), 64'(e.instr));
                    end
                end
                if (resp_valid) begin
                    if (rsp_q.size() == 0) begin
                        check("unexpected_resp", 64'(resp_valid), 64'h0);
                    end else begin
                        r = rsp_q.pop_front();
                        $display("resp cyc=%0d id=%0d fail=%0d instr=%08h", cyc, resp_id, resp_fail, r.instr);
                        check("resp_cycle", 64'(cyc), 64'(r.cyc));
                        check("resp_id", 64'(resp_id), 64'(r.id));
                        check("resp_fail", 64'(resp_fail), 64'(r.fail));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Dependent pair: the second reads the first one's destination.
        rq[0].push_back(32'h2228_0005);
        rq[0].push_back(32'h2117_0001);
        repeat (8) step(1'b0);

        // Independent pair, back-to-back.
        rq[0].push_back(32'h0232_4020);
        rq[0].push_back(32'h2228_0005);
        repeat (8) step(1'b0);

        // Fairness: both requesters busy with instructions writing no tracked register.
        for (int k = 0; k < 3; k++) begin
            rq[0].push_back(32'h0022_1820);
            rq[1].push_back(32'h0043_2020);
        end
        repeat (12) step(1'b0);

        // Illegal instruction followed by one reading its would-be destination.
        rq[0].push_back(32'hFC00_0000);
        rq[0].push_back(32'h2000_0001);
        repeat (8) step(1'b0);

        // Randomised traffic, then drain.
        repeat (500) step(1'b1);
        repeat (12) step(1'b0);
        check("drain_issue_q", 64'(iss_q.size()), 64'h0);
        check("drain_resp_q", 64'(rsp_q.size()), 64'h0);

        // Reset with two instructions in flight.
        rq[0].push_back(32'h0232_4020);
        rq[1].push_back(32'h0043_2020);
        repeat (2) step(1'b0);
        do_reset();
        repeat (8) step(1'b0);

        // Spurious completion sets the sticky protocol error.
        spur_req = 1'b1;
        repeat (6) step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_issue_arbiter.md
# mips_issue_arbiter

Issue controller in front of the 2-stage MIPS datapath. It shares the datapath between `NUM_REQ` instruction requesters using round-robin arbitration. It inserts a one-cycle bubble whenever back-to-back issue would read a register before the datapath has written it. It routes each result's completion and fail flag back to the requester that issued it.

## Interface
- `NUM_REQ`, default 2: requester count, 2..4.
- `MIPS_LAT`, default 2: cycles from `mips_in_valid` to the matching `mips_out_valid`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in `NUM_REQ`: requester i has an instruction.
- `req_instr` in `NUM_REQ`x32: instruction per requester.
- `req_ready` out `NUM_REQ`: an instruction is accepted when valid&ready at a rising edge.
- `mips_in_valid` out 1: registered issue strobe to the datapath.
- `mips_instruction` out 32: registered issued instruction.
- `mips_out_valid` in 1: datapath completion.
- `mips_instruction_fail` in 1: datapath fail flag, qualified by `mips_out_valid`.
- `resp_valid` out 1: registered completion strobe.
- `resp_id` out `$clog2(NUM_REQ)`: owner of the completion.
- `resp_fail` out 1: copy of `mips_instruction_fail`.
- `busy` out 1: an instruction is in flight or being issued.
- `proto_err` out 1: sticky; set when `mips_out_valid` arrives with no matching tag.

## Operation
- Every output resets to 0.
- **Legality.** An instruction is legal when bits 31, 30, 28, 27 and 26 are all 0.
- **Destination.** The destination is `[20:16]` when bit 29=1 (I-type), else `[15:11]`.
- **Writes.** A destination counts as written only if the instruction is legal and the destination is one of 10001, 10010, 01000, 10111, 11111, 10000.
- **Sources.** `rs=[25:21]` is always a source. `rt=[20:16]` is a source only when bit 29=0.
- **Hazard.** A hazard exists when the issue register holds a valid instruction whose written destination equals any source of the arbitration winner.
- **Arbitration.**
  - Round-robin among asserted `req_valid`, starting at pointer `rr_ptr`.
  - The winner's `req_ready`=1 unless there is a hazard. All other readies are 0.
  - On acceptance, `rr_ptr` moves to winner+1, mod `NUM_REQ`. On a stall it holds, so the same winner retries next cycle.
- **Issue register.**
  - On acceptance it loads `mips_instruction` and sets `mips_in_valid`=1.
  - Otherwise `mips_in_valid`=0 and `mips_instruction` holds its old value.
  - A stall cycle therefore produces `mips_in_valid`=0, which is the bubble.
- **Tag pipeline.**
  - A `MIPS_LAT`-deep shift register of {valid, id}, loaded from the issue register.
  - Its head aligns with `mips_out_valid`.
  - When `mips_out_valid`=1: `resp_valid`, `resp_id` and `resp_fail` are registered from the head, and the head is consumed.
  - `mips_out_valid` with an invalid head sets `proto_err` and produces no response.
- **Busy.** `busy` = the issue register is valid, OR any tag is valid.

## Timing
- Accept at edge e → `mips_in_valid` high in cycle e+1 → `mips_out_valid` in cycle e+1+`MIPS_LAT` → `resp_valid` one cycle later.
- Total latency from accept to response: `MIPS_LAT`+2 cycles.
- Throughput is 1 instruction/cycle with no hazard; a hazard costs exactly one bubble.
- A gap of 2 or more cycles clears the hazard, because the datapath writes one cycle after issue.
- Simultaneous `mips_out_valid` and a new issue are independent; the tag shift and load happen in the same cycle.
- Reset mid-operation clears the issue register, tags and `rr_ptr`. In-flight responses are dropped.
- An illegal instruction never creates a hazard. It still issues and gets a response with `resp_fail`=1.

## Configuration
- Macro: `MIPS_HAZARD_STALL_EN`.
- Defined: hazard detection and bubble insertion as described above.
- Undefined: the hazard is forced to 0. The winner always gets ready, giving back-to-back issue, and stale reads are the software's responsibility.

## Structure
- Shared package `mips_pkg`:
  - opcode legality mask
  - the six register address constants
  - functions `dest_of`, `writes_reg`, `reads_rt`
  - typedef `req_id_t`
- Sub-module `rr_arbiter`: a parameterised round-robin arbiter that produces a one-hot grant and takes a pointer-advance input.

## Test plan
- **Dependent pair, macro defined.** Requester 0 sends 0x22280005 (addi reg2=reg0+5), then 0x21170001 (reads reg2), on consecutive cycles → `mips_in_valid` pattern 1,0,1, and `req_ready` low for one cycle.
- **Dependent pair, macro undefined.** Same stimulus → `mips_in_valid` pattern 1,1, no stall.
- **Independent traffic.** 0x02324020 (add reg2=reg0+reg1) followed by 0x22280005 → issued back-to-back. `resp_valid` arrives 4 cycles after each accept with `resp_id`=0 and `resp_fail`=0.
- **Fairness.** Both requesters hold `req_valid` for 6 cycles with independent instructions → grants alternate 0,1,0,1,0,1, and `resp_id` follows the same order.
- **Illegal instruction.** 0xFC000000, then a dependent-looking instruction → no bubble, and that response has `resp_fail`=1.
- **Reset and protocol error.** Assert reset with 2 instructions in flight → all outputs 0, no responses afterwards. Then a spurious `mips_out_valid` → `proto_err`=1 and it stays set.
